// File: rtl/spi_master_param.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : spi_master_param                                           |
// | Description : Parametrised full-duplex SPI master, all CPOL/CPHA modes,   |
// |               MSB/LSB-first order, multiple active-low slave selects.    |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module spi_master_param #(
  parameter int DATA_W  = 8,
  parameter int CLK_DIV = 4,
  parameter int NUM_SS  = 4,
  localparam int SS_W   = (NUM_SS > 1) ? $clog2(NUM_SS) : 1
) (
  input  logic              global_clk,
  input  logic              reset,
  input  logic              start,
  input  logic [SS_W-1:0]   ss_sel,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              cpol,
  input  logic              cpha,
  input  logic              lsb_first,
  output logic [DATA_W-1:0] rx_data,
  output logic              busy,
  output logic              done,
  output logic              sclk,
  output logic              mosi,
  input  logic              miso,
  output logic [NUM_SS-1:0] ss_n
);

  localparam int c_div_w = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int c_bit_w = $clog2(DATA_W);
  localparam logic [c_div_w-1:0] c_div_last = c_div_w'(CLK_DIV - 1);
  localparam logic [c_bit_w-1:0] c_bit_last = c_bit_w'(DATA_W - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SETUP = 3'd1,
    S_XFER  = 3'd2,
    S_HOLD  = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t              r_state;
  state_t              w_next_state;
  logic [c_div_w-1:0]  r_div;
  logic [c_bit_w-1:0]  r_bit;
  logic                r_phase;
  logic                r_sclk;
  logic                r_mosi;
  logic [NUM_SS-1:0]   r_ss_n;
  logic                r_busy;
  logic                r_done;
  logic [DATA_W-1:0]   r_rx_data;
  logic [DATA_W-1:0]   r_tx;
  logic [DATA_W-1:0]   r_rx;
  logic                r_cpol;
  logic                r_cpha;
  logic                r_lsb;

  logic                w_sel_ok;
  logic                w_accept;
  logic                w_div_end;
  logic [NUM_SS-1:0]   w_sel_mask;
  logic                w_first_bit;
  logic [DATA_W-1:0]   w_tx_first;
  logic                w_tx_bit;
  logic [DATA_W-1:0]   w_tx_shifted;
  logic [DATA_W-1:0]   w_rx_shifted;

  assign w_sel_ok   = (32'(ss_sel) < NUM_SS);
  // The done cycle still counts as busy, so a start there is refused too.
  assign w_accept   = (r_state == S_IDLE) && start && w_sel_ok && !r_done;
  assign w_div_end  = (r_div == c_div_last);
  assign w_sel_mask = NUM_SS'(1) << ss_sel;

  assign w_first_bit  = lsb_first ? tx_data[0] : tx_data[DATA_W-1];
  assign w_tx_first   = lsb_first ? (tx_data >> 1) : (tx_data << 1);
  assign w_tx_bit     = r_lsb ? r_tx[0] : r_tx[DATA_W-1];
  assign w_tx_shifted = r_lsb ? (r_tx >> 1) : (r_tx << 1);
  assign w_rx_shifted = r_lsb ? {miso, r_rx[DATA_W-1:1]} : {r_rx[DATA_W-2:0], miso};

  always_ff @(posedge global_clk) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_next_state = S_SETUP;
      S_SETUP: if (w_div_end) w_next_state = S_XFER;
      S_XFER:  if (w_div_end && r_phase && (r_bit == c_bit_last)) w_next_state = S_HOLD;
      S_HOLD:  if (w_div_end) w_next_state = S_DONE;
      S_DONE:  w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge global_clk) begin
    if (!reset) begin
      r_div     <= '0;
      r_bit     <= '0;
      r_phase   <= 1'b0;
      r_sclk    <= 1'b0;
      r_mosi    <= 1'b0;
      r_ss_n    <= '1;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_rx_data <= '0;
      r_tx      <= '0;
      r_rx      <= '0;
      r_cpol    <= 1'b0;
      r_cpha    <= 1'b0;
      r_lsb     <= 1'b0;
    end else begin
      r_done <= (r_state == S_DONE);
      if (r_state == S_DONE) r_rx_data <= r_rx;
      if (w_accept)    r_busy <= 1'b1;
      else if (r_done) r_busy <= 1'b0;
      r_div <= ((r_state == S_IDLE) || w_div_end) ? '0 : r_div + c_div_w'(1);

      case (r_state)
        S_IDLE: begin
          r_sclk <= r_cpol;
          if (w_accept) begin
            r_cpol  <= cpol;
            r_cpha  <= cpha;
            r_lsb   <= lsb_first;
            r_sclk  <= cpol;
            r_ss_n  <= ~w_sel_mask;
            r_bit   <= '0;
            r_phase <= 1'b0;
            r_rx    <= '0;
            // CPHA=0 puts the first bit on the wire before the first edge.
            if (!cpha) begin
              r_mosi <= w_first_bit;
              r_tx   <= w_tx_first;
            end else begin
              r_tx   <= tx_data;
            end
          end
        end
        S_XFER: begin
          if (w_div_end) begin
            r_sclk  <= ~r_sclk;
            r_phase <= ~r_phase;
            if (r_phase && (r_bit != c_bit_last)) r_bit <= r_bit + c_bit_w'(1);
            if (r_phase == r_cpha) begin
              r_rx <= w_rx_shifted;
            end else if (r_cpha || (r_bit != c_bit_last)) begin
              r_mosi <= w_tx_bit;
              r_tx   <= w_tx_shifted;
            end
          end
        end
        S_HOLD: begin
          if (w_div_end) begin
            r_ss_n <= '1;
            r_mosi <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign rx_data = r_rx_data;
  assign busy    = r_busy;
  assign done    = r_done;
  assign sclk    = r_sclk;
  assign mosi    = r_mosi;
  assign ss_n    = r_ss_n;

endmodule
`default_nettype wire

// File: tb/tb_spi_master_param.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_spi_master_param                                        |
// | Description : Self-checking bench for spi_master_param with slave model. |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_spi_master_param;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [1:0] ss_sel;
  logic [7:0] tx_data;
  logic       cpol, cpha, lsb_first;
  logic [7:0] rx_data;
  logic       busy, done, sclk, mosi, miso;
  logic [3:0] ss_n;

  logic       start5;
  logic [2:0] ss_sel5;
  logic [7:0] rx5;
  logic       busy5, done5, sclk5, mosi5;
  logic [4:0] ss_n5;

  logic       loop_en;
  logic       slv_miso;
  logic       slv_cpol, slv_cpha;
  logic [7:0] slv_tx, slv_sh, slv_rx;
  int         slv_cnt, rise_cnt;
  logic       prev_act, prev_sclk;

  int         errors = 0;
  int         checks = 0;
  logic [7:0] exp_q[$];

  always #5 clk = ~clk;

  assign miso = loop_en ? mosi : slv_miso;

  spi_master_param #(.DATA_W(8), .CLK_DIV(4), .NUM_SS(4)) dut (
    .global_clk(clk), .reset(reset), .start(start), .ss_sel(ss_sel),
    .tx_data(tx_data), .cpol(cpol), .cpha(cpha), .lsb_first(lsb_first),
    .rx_data(rx_data), .busy(busy), .done(done), .sclk(sclk), .mosi(mosi),
    .miso(miso), .ss_n(ss_n)
  );

  spi_master_param #(.DATA_W(8), .CLK_DIV(4), .NUM_SS(5)) dut5 (
    .global_clk(clk), .reset(reset), .start(start5), .ss_sel(ss_sel5),
    .tx_data(8'h55), .cpol(1'b0), .cpha(1'b0), .lsb_first(1'b0),
    .rx_data(rx5), .busy(busy5), .done(done5), .sclk(sclk5), .mosi(mosi5),
    .miso(1'b0), .ss_n(ss_n5)
  );

  // Cycle-sampled SPI slave: captures mosi MSB-first on its sample edge and,
  // for CPHA=1, shifts slv_tx out MSB-first on the leading edge.
  always @(negedge clk) begin
    logic act, lead;
    act = (ss_n != 4'hF);
    if (act && !prev_act) begin
      slv_cnt  <= 0;
      rise_cnt <= 0;
      slv_rx   <= 8'h00;
      slv_sh   <= slv_tx;
    end else if (act && prev_act && (sclk != prev_sclk)) begin
      lead = (prev_sclk == slv_cpol);
      if (sclk) rise_cnt <= rise_cnt + 1;
      if (lead != slv_cpha) begin
        slv_rx  <= {slv_rx[6:0], mosi};
        slv_cnt <= slv_cnt + 1;
      end else if (slv_cpha) begin
        slv_miso <= slv_sh[7];
        slv_sh   <= {slv_sh[6:0], 1'b0};
      end
    end
    prev_act  <= act;
    prev_sclk <= sclk;
  end

  task automatic run_xfer(input logic [7:0] tx, input logic [1:0] sel, input logic pol,
                          input logic pha, input logic lsb, input int repulse_at,
                          output int lat, output logic got, output logic [3:0] ss_mid,
                          output logic busy_done);
    repeat (2) @(negedge clk);
    tx_data = tx; ss_sel = sel; cpol = pol; cpha = pha; lsb_first = lsb;
    slv_cpol = pol; slv_cpha = pha;
    start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    lat = 0; got = 1'b0; ss_mid = 4'hF; busy_done = 1'b0;
    while (!got && lat < 300) begin
      @(posedge clk); lat++; #1;
      if (lat == 10) ss_mid = ss_n;
      if (repulse_at != 0 && lat == repulse_at) begin
        tx_data = ~tx; ss_sel = sel + 2'd1; cpha = ~pha; start = 1'b1;
      end
      if (repulse_at != 0 && lat == repulse_at + 2) start = 1'b0;
      if (done) begin
        got = 1'b1;
        busy_done = busy;
      end
    end
  endtask

  task automatic test_reset;
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (sclk !== 1'b0) begin errors++; $display("FAIL reset_sclk: got %b expected 0", sclk); end
    checks++; if (mosi !== 1'b0) begin errors++; $display("FAIL reset_mosi: got %b expected 0", mosi); end
    checks++; if (ss_n !== 4'hF) begin errors++; $display("FAIL reset_ss_n: got %b expected 1111", ss_n); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", done); end
    checks++; if (rx_data !== 8'h00) begin errors++; $display("FAIL reset_rx: got %h expected 00", rx_data); end
    @(negedge clk) reset = 1'b1;
  endtask

  task automatic test_mode0_loopback;
    int lat; logic got, bd; logic [3:0] ssm; logic [7:0] exp;
    loop_en = 1'b1;
    exp_q.push_back(8'hA5);
    run_xfer(8'hA5, 2'd0, 1'b0, 1'b0, 1'b0, 0, lat, got, ssm, bd);
    exp = exp_q.pop_front();
    checks++; if (!got || rx_data !== exp) begin errors++; $display("FAIL t1_rx: got %h done=%b expected %h", rx_data, got, exp); end
    checks++; if (lat !== 73) begin errors++; $display("FAIL t1_latency: got %0d expected 73", lat); end
    checks++; if (ssm !== 4'b1110) begin errors++; $display("FAIL t1_ss_n: got %b expected 1110", ssm); end
    checks++; if (bd !== 1'b1) begin errors++; $display("FAIL t1_busy_at_done: got %b expected 1", bd); end
    @(posedge clk); #1;
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL t1_done_pulse: got %b expected 0", done); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL t1_busy_after: got %b expected 0", busy); end
  endtask

  task automatic test_mode3_slave;
    int lat; logic got, bd; logic [3:0] ssm; logic [7:0] exp;
    loop_en = 1'b0;
    slv_tx = 8'h3C;
    exp_q.push_back(8'h3C);
    run_xfer(8'h5A, 2'd0, 1'b1, 1'b1, 1'b0, 0, lat, got, ssm, bd);
    exp = exp_q.pop_front();
    checks++; if (!got || rx_data !== exp) begin errors++; $display("FAIL t2_rx: got %h done=%b expected %h", rx_data, got, exp); end
    checks++; if (slv_rx !== 8'h5A) begin errors++; $display("FAIL t2_slave_rx: got %h expected 5a", slv_rx); end
    checks++; if (rise_cnt !== 8) begin errors++; $display("FAIL t2_rising_edges: got %0d expected 8", rise_cnt); end
    checks++; if (slv_cnt !== 8) begin errors++; $display("FAIL t2_samples: got %0d expected 8", slv_cnt); end
    @(posedge clk); #1;
    checks++; if (sclk !== 1'b1) begin errors++; $display("FAIL t2_sclk_idle: got %b expected 1", sclk); end
  endtask

  task automatic test_lsb_first;
    int lat; logic got, bd; logic [3:0] ssm; logic [7:0] exp;
    loop_en = 1'b1;
    exp_q.push_back(8'h01);
    run_xfer(8'h01, 2'd0, 1'b0, 1'b1, 1'b1, 0, lat, got, ssm, bd);
    exp = exp_q.pop_front();
    checks++; if (!got || rx_data !== exp) begin errors++; $display("FAIL t3_rx: got %h done=%b expected %h", rx_data, got, exp); end
    checks++; if (slv_rx !== 8'h80) begin errors++; $display("FAIL t3_wire_order: got %b expected 10000000", slv_rx); end
    checks++; if (slv_cnt !== 8) begin errors++; $display("FAIL t3_samples: got %0d expected 8", slv_cnt); end
  endtask

  task automatic test_slave_select;
    int lat, n_busy, n_done, n_tog; logic got, bd, prev; logic [3:0] ssm; logic [4:0] ss5;
    logic [7:0] exp;
    loop_en = 1'b1;
    exp_q.push_back(8'hC3);
    run_xfer(8'hC3, 2'd2, 1'b0, 1'b0, 1'b0, 0, lat, got, ssm, bd);
    exp = exp_q.pop_front();
    checks++; if (ssm !== 4'b1011) begin errors++; $display("FAIL t4_ss_sel2: got %b expected 1011", ssm); end
    checks++; if (!got || rx_data !== exp) begin errors++; $display("FAIL t4_rx: got %h done=%b expected %h", rx_data, got, exp); end
    exp_q.push_back(8'h7E);
    run_xfer(8'h7E, 2'd3, 1'b0, 1'b0, 1'b0, 0, lat, got, ssm, bd);
    exp = exp_q.pop_front();
    checks++; if (ssm !== 4'b0111) begin errors++; $display("FAIL t4_ss_sel3: got %b expected 0111", ssm); end
    checks++; if (!got || rx_data !== exp) begin errors++; $display("FAIL t4_rx3: got %h done=%b expected %h", rx_data, got, exp); end
    // Out-of-range select on the five-slave instance must be ignored.
    @(negedge clk) ss_sel5 = 3'd5; start5 = 1'b1;
    @(negedge clk) start5 = 1'b0;
    n_busy = 0; n_done = 0; n_tog = 0; ss5 = 5'h1F; prev = sclk5;
    repeat (90) begin
      @(posedge clk); #1;
      if (busy5) n_busy++;
      if (done5) n_done++;
      if (sclk5 != prev) n_tog++;
      prev = sclk5;
      ss5 = ss5 & ss_n5;
    end
    checks++; if (n_busy !== 0) begin errors++; $display("FAIL t4_bad_sel_busy: got %0d busy cycles expected 0", n_busy); end
    checks++; if (n_done !== 0) begin errors++; $display("FAIL t4_bad_sel_done: got %0d done pulses expected 0", n_done); end
    checks++; if (n_tog !== 0) begin errors++; $display("FAIL t4_bad_sel_sclk: got %0d toggles expected 0", n_tog); end
    checks++; if (ss5 !== 5'h1F) begin errors++; $display("FAIL t4_bad_sel_ss_n: got %b expected 11111", ss5); end
  endtask

  task automatic test_back_to_back;
    int lat, n_done; logic got, bd; logic [3:0] ssm; logic [7:0] exp;
    loop_en = 1'b1;
    exp_q.push_back(8'h96);
    run_xfer(8'h96, 2'd0, 1'b0, 1'b0, 1'b0, 20, lat, got, ssm, bd);
    exp = exp_q.pop_front();
    checks++; if (!got || rx_data !== exp) begin errors++; $display("FAIL t5_rx: got %h done=%b expected %h", rx_data, got, exp); end
    checks++; if (lat !== 73) begin errors++; $display("FAIL t5_latency: got %0d expected 73", lat); end
    n_done = 0;
    repeat (100) begin
      @(posedge clk); #1;
      if (done) n_done++;
    end
    checks++; if (n_done !== 0) begin errors++; $display("FAIL t5_extra_done: got %0d expected 0", n_done); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL t5_busy_after: got %b expected 0", busy); end
  endtask

  task automatic test_reset_abort;
    int lat, n_done; logic got, bd; logic [3:0] ssm; logic [7:0] exp;
    loop_en = 1'b1;
    repeat (2) @(negedge clk);
    tx_data = 8'hF0; ss_sel = 2'd0; cpol = 1'b0; cpha = 1'b0; lsb_first = 1'b0;
    start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (30) @(posedge clk);
    @(negedge clk) reset = 1'b0;
    @(posedge clk); #1;
    checks++; if (ss_n !== 4'hF) begin errors++; $display("FAIL t6_ss_n: got %b expected 1111", ss_n); end
    checks++; if (sclk !== 1'b0) begin errors++; $display("FAIL t6_sclk: got %b expected 0", sclk); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL t6_busy: got %b expected 0", busy); end
    checks++; if (rx_data !== 8'h00) begin errors++; $display("FAIL t6_rx_cleared: got %h expected 00", rx_data); end
    @(negedge clk) reset = 1'b1;
    n_done = 0;
    repeat (100) begin
      @(posedge clk); #1;
      if (done) n_done++;
    end
    checks++; if (n_done !== 0) begin errors++; $display("FAIL t6_no_done: got %0d expected 0", n_done); end
    exp_q.push_back(8'h3E);
    run_xfer(8'h3E, 2'd1, 1'b0, 1'b0, 1'b0, 0, lat, got, ssm, bd);
    exp = exp_q.pop_front();
    checks++; if (!got || rx_data !== exp) begin errors++; $display("FAIL t6_fresh_rx: got %h done=%b expected %h", rx_data, got, exp); end
    checks++; if (lat !== 73) begin errors++; $display("FAIL t6_fresh_latency: got %0d expected 73", lat); end
  endtask

  initial begin
    start = 1'b0; ss_sel = 2'd0; tx_data = 8'h00;
    cpol = 1'b0; cpha = 1'b0; lsb_first = 1'b0;
    start5 = 1'b0; ss_sel5 = 3'd0;
    loop_en = 1'b1; slv_miso = 1'b0; slv_cpol = 1'b0; slv_cpha = 1'b0; slv_tx = 8'h00;
    test_reset();
    test_mode0_loopback();
    test_mode3_slave();
    test_lsb_first();
    test_slave_select();
    test_back_to_back();
    test_reset_abort();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
